dmem_access_ctrl: RTL and testbench

//  Responder to the control unit's memory strobes (MemRd/MemWr) for lw/sw. Turns a single-cycle

---
 rtl/dmem_access_ctrl_pkg.sv | 14 +
 rtl/dmem_access_ctrl_if.sv | 23 ++
 rtl/dmem_access_ctrl_timer.sv | 27 ++
 rtl/dmem_access_ctrl.sv | 119 +++++++++++
 tb/tb_dmem_access_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
// The FSM state enum, the default timeout and the word-alignment mask.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam int         TIMEOUT_DEF = 64;
    localparam logic [1:0] ALIGN_MASK  = 2'b11;

    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Valid/ready request plus un-backpressured response channel to data memory.
interface dmem_bus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_rdata;

    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl_timer.sv
// Cycle counter for an outstanding access; expire flags the last allowed cycle.
module access_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // expire is high during the TIMEOUT-th cycle since clear, so the next edge leaves
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expire)
            cnt <= cnt + CW'(1);
    end

    assign expire = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_access_ctrl.sv
// Turns single-cycle lw/sw strobes into a valid/ready DMem transaction,
// stalling the pipeline until completion; adds alignment, timeout and perf counters.
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_mem_rd,
    input  logic              cpu_mem_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    dmem_bus_if.master        mem,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
);
    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q, to_q;
    logic              req, aligned, start, bad;
    logic              tmr_en, expired, timeout_hit;

    assign req     = cpu_mem_rd ^ cpu_mem_wr;
    assign aligned = is_aligned(cpu_addr[1:0]);
    assign start   = (state == IDLE) && req && aligned;
    assign bad     = (state == IDLE) && ((req && !aligned) || (cpu_mem_rd && cpu_mem_wr));
    assign tmr_en  = (state == REQ) || (state == WAIT);
    // A response landing on the final cycle still completes normally
    assign timeout_hit = tmr_en && expired && !((state == WAIT) && mem.mem_resp_valid);

    access_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start),
        .en     (tmr_en),
        .expire (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = REQ;
            REQ:     if (timeout_hit) state_nx = DONE;
                     else if (mem.mem_req_ready) state_nx = WAIT;
            WAIT:    if (mem.mem_resp_valid || timeout_hit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cpu_stall         = 1'b0;
        cpu_done          = 1'b0;
        cpu_err           = 1'b0;
        mem.mem_req_valid = 1'b0;
        unique case (state)
            IDLE: begin
                cpu_stall = start;
                cpu_err   = bad;
            end
            REQ: begin
                cpu_stall         = 1'b1;
                mem.mem_req_valid = 1'b1;
            end
            WAIT:    cpu_stall = 1'b1;
            DONE: begin
                cpu_done = 1'b1;
                cpu_err  = to_q;
            end
            default: ;
        endcase
    end

    assign mem.mem_req_we    = we_q;
    assign mem.mem_req_addr  = addr_q;
    assign mem.mem_req_wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            to_q      <= 1'b0;
            cpu_rdata <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            if (start) begin
                addr_q  <= cpu_addr & ~ADDR_W'(ALIGN_MASK);
                wdata_q <= cpu_wdata;
                we_q    <= cpu_mem_wr;
                to_q    <= 1'b0;
            end
            if (timeout_hit)
                to_q <= 1'b1;
            if ((state == WAIT) && mem.mem_resp_valid && !we_q)
                cpu_rdata <= mem.mem_resp_rdata;
            // Aborted accesses are not counted
            if ((state == DONE) && !to_q) begin
                if (we_q) wr_count <= wr_count + 32'd1;
                else      rd_count <= rd_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed vector bench for dmem_access_ctrl with a cycle-scheduled DMem responder.
module tb_dmem_access_ctrl;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_mem_rd = 1'b0, cpu_mem_wr = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_stall, cpu_done, cpu_err;
    logic [31:0] cpu_rdata, rd_count, wr_count;
    int          checks = 0, errors = 0;

    dmem_bus_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_mem_rd (cpu_mem_rd),
        .cpu_mem_wr (cpu_mem_wr),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_done   (cpu_done),
        .cpu_rdata  (cpu_rdata),
        .cpu_err    (cpu_err),
        .mem        (bus.master),
        .rd_count   (rd_count),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd, wr;
        logic [31:0] addr, wdata;
        int          ready_dly, resp_dly;
        bit          no_resp, stray;
        logic [31:0] rdata;
        int          e_done, e_stall, e_valid, e_err;
        logic        e_err_done;
        logic [31:0] e_rdata, e_rd, e_wr;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Entered and left at posedge+1; the next request may be applied immediately
    task automatic apply(input vec_t v);
        int   cyc = 0, acc = -1, vcnt = 0;
        int   nstall = 0, nvalid = 0, nerr = 0, done_cyc = -1;
        logic err_done = 1'b0;
        bit   fields_ok = 1'b1, fin = 1'b0;
        cpu_mem_rd = v.rd; cpu_mem_wr = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata;
        while (cyc < 60 && !fin) begin
            @(negedge clk);
            if (cpu_stall) nstall++;
            if (cpu_err) nerr++;
            if (bus.mem_req_valid) begin
                nvalid++;
                if (bus.mem_req_addr !== (v.addr & ~32'h3) || bus.mem_req_we !== v.wr ||
                    bus.mem_req_wdata !== v.wdata) fields_ok = 1'b0;
            end
            if (cpu_done) begin
                done_cyc = cyc; err_done = cpu_err; fin = 1'b1;
            end else if (cyc == 0 && !cpu_stall) fin = 1'b1;
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_rdata = '0;
            bus.mem_req_ready  = 1'b0;
            if (!fin) begin
                if (!v.no_resp && acc >= 0 && cyc == acc + v.resp_dly) begin
                    bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = v.rdata;
                end else if (v.stray && bus.mem_req_valid) begin
                    bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = ~v.rdata;
                end
                bus.mem_req_ready = bus.mem_req_valid && (vcnt >= v.ready_dly);
                if (bus.mem_req_valid) vcnt++;
                if (bus.mem_req_valid && bus.mem_req_ready) acc = cyc;
            end else begin
                cpu_mem_rd = 1'b0; cpu_mem_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
            end
            cyc++;
        end
        chk({v.name, ".bound"}, 32'(fin), 32'd1);
        cpu_mem_rd = 1'b0; cpu_mem_wr = 1'b0;
        if (done_cyc < 0) repeat (2) begin
            @(negedge clk);
            if (bus.mem_req_valid) nvalid++;
            if (cpu_stall) nstall++;
        end
        @(posedge clk); #1;
        chk({v.name, ".done_cyc"}, 32'(done_cyc), 32'(v.e_done));
        chk({v.name, ".stall_cycles"}, 32'(nstall), 32'(v.e_stall));
        chk({v.name, ".valid_cycles"}, 32'(nvalid), 32'(v.e_valid));
        chk({v.name, ".err_cycles"}, 32'(nerr), 32'(v.e_err));
        chk({v.name, ".err_at_done"}, 32'(err_done), 32'(v.e_err_done));
        chk({v.name, ".req_fields"}, 32'(fields_ok), 32'd1);
        chk({v.name, ".cpu_rdata"}, cpu_rdata, v.e_rdata);
        chk({v.name, ".rd_count"}, rd_count, v.e_rd);
        chk({v.name, ".wr_count"}, wr_count, v.e_wr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   seen;
        vec_t wrap_v;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = '0;
        //            name          rd wr addr      wdata        rdy resp nr st rdata         done st vl er ed rdata         rd wr
        vecs[0] = '{"lw_min",       1, 0, 32'h10, 32'h0,        0,  1,  0, 0, 32'hCAFEF00D, 3,   3, 1, 0, 0, 32'hCAFEF00D, 1, 0};
        vecs[1] = '{"sw_backpr",    0, 1, 32'h20, 32'h12345678, 4,  1,  0, 0, 32'hFFFFFFFF, 7,   7, 5, 0, 0, 32'hCAFEF00D, 1, 1};
        vecs[2] = '{"lw_misal",     1, 0, 32'h13, 32'h0,        0,  1,  0, 0, 32'h0,        -1,  0, 0, 1, 0, 32'hCAFEF00D, 1, 1};
        vecs[3] = '{"lw_timeout",   1, 0, 32'h40, 32'h0,        0,  1,  1, 0, 32'h0,        TO+1, TO+1, 1, 1, 1, 32'hCAFEF00D, 1, 1};
        vecs[4] = '{"rd_wr_both",   1, 1, 32'h50, 32'h0,        0,  1,  0, 0, 32'h0,        -1,  0, 0, 1, 0, 32'hCAFEF00D, 1, 1};
        vecs[5] = '{"sw_slow_resp", 0, 1, 32'h24, 32'hA5A5A5A5, 0,  3,  0, 0, 32'h55555555, 5,   5, 1, 0, 0, 32'hCAFEF00D, 1, 2};
        vecs[6] = '{"lw_backpr",    1, 0, 32'h30, 32'h0,        2,  2,  0, 0, 32'h0BADBEEF, 6,   6, 3, 0, 0, 32'h0BADBEEF, 2, 2};
        vecs[7] = '{"sw_misal",     0, 1, 32'h22, 32'h99,       0,  1,  0, 0, 32'h0,        -1,  0, 0, 1, 0, 32'h0BADBEEF, 2, 2};
        vecs[8] = '{"to_noready",   1, 0, 32'h44, 32'h0,        100, 1, 1, 1, 32'h77777777, TO+1, TO+1, TO, 1, 1, 32'h0BADBEEF, 2, 2};
        vecs[9] = '{"lw_stray",     1, 0, 32'h60, 32'h0,        0,  2,  0, 1, 32'h11112222, 4,   4, 1, 0, 0, 32'h11112222, 3, 2};

        repeat (3) @(posedge clk);
        #1;
        chk("rst.cpu_stall", 32'(cpu_stall), 32'd0);
        chk("rst.cpu_done", 32'(cpu_done), 32'd0);
        chk("rst.cpu_err", 32'(cpu_err), 32'd0);
        chk("rst.req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst.req_we", 32'(bus.mem_req_we), 32'd0);
        chk("rst.req_addr", bus.mem_req_addr, 32'd0);
        chk("rst.req_wdata", bus.mem_req_wdata, 32'd0);
        chk("rst.cpu_rdata", cpu_rdata, 32'd0);
        chk("rst.rd_count", rd_count, 32'd0);
        chk("rst.wr_count", wr_count, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) apply(vecs[i]);

        // Reset while waiting for a response, then a late response arrives
        cpu_mem_rd = 1'b1; cpu_addr = 32'h70; bus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        chk("rstwait.req_valid", 32'(bus.mem_req_valid), 32'd1);
        @(posedge clk); #1;
        chk("rstwait.stall_in_wait", 32'(cpu_stall), 32'd1);
        cpu_mem_rd = 1'b0; cpu_addr = '0; bus.mem_req_ready = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 32'hDEADBEEF;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_done || cpu_stall || bus.mem_req_valid) seen = 1'b1;
            bus.mem_resp_valid = 1'b0;
        end
        @(posedge clk); #1;
        chk("rstwait.no_activity", 32'(seen), 32'd0);
        chk("rstwait.cpu_rdata", cpu_rdata, 32'd0);
        chk("rstwait.rd_count", rd_count, 32'd0);
        chk("rstwait.wr_count", wr_count, 32'd0);

        // Load counter wrap
        force dut.rd_count = 32'hFFFF_FFFF;
        #1;
        release dut.rd_count;
        wrap_v = '{"rd_wrap", 1, 0, 32'h80, 32'h0, 0, 1, 0, 0, 32'h600DF00D,
                   3, 3, 1, 0, 0, 32'h600DF00D, 32'h0, 32'h0};
        apply(wrap_v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
